// File: rtl/ifetch_unit_if.sv
// Fetch-side bus bundle: instruction ROM request/return, decode handshake and
// execute redirect. The fetch unit is the master; ROM, decode and execute
// together form the slave side.
interface ifetch_unit_if;
  logic [31:0] imrom_addr;
  logic [31:0] imrom_out;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imrom_addr, if_valid, if_instr, if_pc,
    input  imrom_out, if_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imrom_addr, if_valid, if_instr, if_pc,
    output imrom_out, if_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end. Holds the PC, addresses a synchronous ROM with
// ROM_LATENCY cycles of read latency, collects returned words into an
// FQ_DEPTH-entry queue and presents {pc, instr} to decode over valid/ready.
// Redirects from execute flush the queue and squash in-flight reads.
// Optional build macro: IFETCH_PERF_EN adds fetch/stall performance counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned FQ_DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned CW = $clog2(FQ_DEPTH + ROM_LATENCY + 1) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  logic [31:0]            pc;
  logic [ROM_LATENCY-1:0] pipe_v;
  logic [31:0]            pipe_tag [ROM_LATENCY];
  fq_entry_t              fq_mem [FQ_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [OW-1:0]          occ;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          credit_used;
  logic [CW-1:0]          credit_limit;
  logic                   head_valid;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   redirect;
  logic                   unused_redirect_lsbs;

  assign redirect             = bus.redirect_valid;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // Count ROM reads still in flight; each one already owns a queue slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(ROM_LATENCY); i++) begin
      inflight = inflight + CW'(pipe_v[i]);
    end
  end

  assign head_valid   = (occ != '0);
  assign full         = (occ == OW'(FQ_DEPTH));
  assign pop          = head_valid && bus.if_ready;
  assign push         = pipe_v[ROM_LATENCY-1];
  assign credit_used  = CW'(occ) + inflight;
  assign credit_limit = CW'(FQ_DEPTH) + CW'(pop);
  // Issue only when the read is guaranteed a queue slot on return.
  assign issue        = !redirect && (credit_used < credit_limit);

  // Program counter: redirect wins, otherwise advance on every issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {bus.redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      pc <= pc + 32'd4;
    end
  end

  // In-flight pipe mirroring ROM latency; the pc tag travels with its read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < int'(ROM_LATENCY); i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      for (int i = int'(ROM_LATENCY) - 1; i > 0; i--) begin
        pipe_v[i]   <= pipe_v[i-1] && !redirect;
        pipe_tag[i] <= pipe_tag[i-1];
      end
      pipe_v[0]   <= issue;
      pipe_tag[0] <= pc;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  // Queue storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      fq_mem[wr_ptr] <= '{pc: pipe_tag[ROM_LATENCY-1], instr: bus.imrom_out};
    end
  end

  assign bus.imrom_addr = {2'b00, pc[31:2]};
  assign bus.if_valid   = head_valid;
  assign bus.if_pc      = head_valid ? fq_mem[rd_ptr].pc    : 32'h0;
  assign bus.if_instr   = head_valid ? fq_mem[rd_ptr].instr : 32'h0;

`ifdef IFETCH_PERF_EN
  // Performance counters: issued fetches and decode back-pressure cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (head_valid && !bus.if_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

  // A return landing on a full queue means the credit accounting is broken.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
